pool_fmap_ping_pong_reader: RTL and testbench

//  Receiver for the conv2 2x2 max-pool output stream. It collects one POOL_W x POOL_H pooled map per filter into
//  a ping-pong bank pair, then replays each completed map to the next stage (FC / flatten) over a

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/fmap_dpram.sv | 22 ++
 rtl/pool_fmap_ping_pong_reader.sv | 214 +++++++++++++++++++++
 tb/tb_pool_fmap_ping_pong_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and read-FSM encoding for the pooled feature-map
// ping-pong buffer.
package cnn_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int POOL_W      = 12;
    localparam int POOL_H      = 12;
    localparam int NUM_FILTERS = 16;
    localparam int MAP_SIZE    = POOL_W * POOL_H;
    localparam int ADDR_W      = $clog2(MAP_SIZE);
    localparam int FILT_W      = $clog2(NUM_FILTERS);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_SIZE - 1);
    localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_DRAIN
    } rd_state_t;

    // Bank 1 sits directly above bank 0 so the RAM is exactly 2*MAP_SIZE deep
    function automatic logic [ADDR_W:0] bank_addr(
        input logic              bank,
        input logic [ADDR_W-1:0] idx
    );
        return {1'b0, idx} + (bank ? (ADDR_W + 1)'(MAP_SIZE) : '0);
    endfunction
endpackage

// File: rtl/fmap_dpram.sv
// Simple dual-port RAM holding both ping-pong banks.
// Registered read, one cycle of latency.
module fmap_dpram
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W:0]       rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2*MAP_SIZE];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/pool_fmap_ping_pong_reader.sv
// Collects pooled maps into a ping-pong bank pair and replays each
// completed map downstream through a 2-entry skid buffer.
module pool_fmap_ping_pong_reader
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_filter,
    input  logic                  pool_valid,
    input  logic [DATA_WIDTH-1:0] pool_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [FILT_W-1:0]     out_filter_idx,
    output logic [1:0]            bank_full,
    output logic                  err_overflow,
    output logic                  err_short
);
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic [FILT_W-1:0] wr_filt;
    logic [FILT_W-1:0] filt_tag [2];
    logic              wr_en;
    logic [1:0]        bf_set;
    logic [1:0]        bf_clr;

    rd_state_t         state;
    rd_state_t         state_n;
    logic              rd_bank;
    logic              rd_bank_n;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_cnt_n;
    logic              rd_en;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_idx;
    logic              issue_last;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  pend;
    logic                  pend_last;
    logic [DATA_WIDTH-1:0] sk_data [2];
    logic                  sk_last [2];
    logic [1:0]            sk_cnt;
    logic                  pop;
    logic                  can_issue;

    assign wr_en = pool_valid && !new_filter && !bank_full[wr_bank];

    always_comb begin
        bf_set = '0;
        if (wr_en && wr_cnt == LAST_ADDR)
            bf_set[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank      <= 1'b0;
            wr_cnt       <= '0;
            wr_filt      <= '0;
            filt_tag[0]  <= '0;
            filt_tag[1]  <= '0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else if (new_filter) begin
            if (wr_cnt != '0) begin
                wr_cnt    <= '0;
                err_short <= 1'b1;
            end
        end else if (pool_valid) begin
            if (bank_full[wr_bank]) begin
                err_overflow <= 1'b1;
            end else if (wr_cnt == LAST_ADDR) begin
                wr_cnt            <= '0;
                wr_bank           <= ~wr_bank;
                filt_tag[wr_bank] <= wr_filt;
                wr_filt <= (wr_filt == LAST_FILT) ? '0 : wr_filt + 1'b1;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            bank_full <= '0;
        else
            bank_full <= (bank_full | bf_set) & ~bf_clr;
    end

    fmap_dpram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (bank_addr(wr_bank, wr_cnt)),
        .wr_data (pool_data),
        .rd_en   (rd_en),
        .rd_addr (bank_addr(rd_sel, rd_idx)),
        .rd_data (rd_data)
    );

    assign out_valid      = (sk_cnt != 2'd0);
    assign out_data       = sk_data[0];
    assign out_last       = out_valid && sk_last[0];
    assign out_filter_idx = filt_tag[rd_bank];
    assign pop            = out_valid && out_ready;

    // A read may go out if the buffer, counting the read in flight, keeps a slot
    assign can_issue = ({1'b0, sk_cnt} + {2'b0, pend}) < (3'd2 + {2'b0, pop});

    always_comb begin
        state_n    = state;
        rd_cnt_n   = rd_cnt;
        rd_bank_n  = rd_bank;
        rd_en      = 1'b0;
        rd_sel     = rd_bank;
        rd_idx     = rd_cnt;
        issue_last = 1'b0;
        bf_clr     = '0;
        unique case (state)
            RD_IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_en    = 1'b1;
                    rd_idx   = '0;
                    rd_cnt_n = ADDR_W'(1);
                    state_n  = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    if (rd_cnt == LAST_ADDR) begin
                        issue_last = 1'b1;
                        rd_cnt_n   = '0;
                        state_n    = RD_DRAIN;
                    end else begin
                        rd_cnt_n = rd_cnt + 1'b1;
                    end
                end
            end
            RD_DRAIN: begin
                if (pop && out_last) begin
                    bf_clr[rd_bank] = 1'b1;
                    rd_bank_n       = ~rd_bank;
                    state_n         = RD_IDLE;
                    if (bank_full[~rd_bank]) begin
                        rd_en    = 1'b1;
                        rd_sel   = ~rd_bank;
                        rd_idx   = '0;
                        rd_cnt_n = ADDR_W'(1);
                        state_n  = RD_STREAM;
                    end
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RD_IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_n;
            rd_bank   <= rd_bank_n;
            rd_cnt    <= rd_cnt_n;
            pend      <= rd_en;
            pend_last <= issue_last;
        end
    end

    // Slot 0 is the presented beat; slot 1 absorbs the in-flight read on a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            sk_cnt     <= 2'd0;
            sk_data[0] <= '0;
            sk_data[1] <= '0;
            sk_last[0] <= 1'b0;
            sk_last[1] <= 1'b0;
        end else begin
            unique case ({pop, pend})
                2'b01: begin
                    if (sk_cnt == 2'd0) begin
                        sk_data[0] <= rd_data;
                        sk_last[0] <= pend_last;
                    end else begin
                        sk_data[1] <= rd_data;
                        sk_last[1] <= pend_last;
                    end
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b10: begin
                    sk_data[0] <= sk_data[1];
                    sk_last[0] <= sk_last[1];
                    sk_cnt     <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        sk_data[0] <= rd_data;
                        sk_last[0] <= pend_last;
                    end else begin
                        sk_data[0] <= sk_data[1];
                        sk_last[0] <= sk_last[1];
                        sk_data[1] <= rd_data;
                        sk_last[1] <= pend_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_fmap_ping_pong_reader.sv
// Randomised bench with a queue-based map model and directed
// literal checks for latency, flags and reset behaviour.
module tb_pool_fmap_ping_pong_reader;
    import cnn_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  new_filter = 1'b0;
    logic                  pool_valid = 1'b0;
    logic [DATA_WIDTH-1:0] pool_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [FILT_W-1:0]     out_filter_idx;
    logic [1:0]            bank_full;
    logic                  err_overflow;
    logic                  err_short;

    pool_fmap_ping_pong_reader dut (
        .clk            (clk),
        .reset          (reset),
        .new_filter     (new_filter),
        .pool_valid     (pool_valid),
        .pool_data      (pool_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_filter_idx (out_filter_idx),
        .bank_full      (bank_full),
        .err_overflow   (err_overflow),
        .err_short      (err_short)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: partial map, completed maps awaiting replay, sticky errors
    logic [7:0] part[$];
    logic [7:0] exp_pix[$];
    int         map_filt[$];
    int         map_bank[$];
    int         m_filt = 0;
    int         m_seq = 0;
    bit         m_ovf = 0;
    bit         m_short = 0;
    int         beat = 0;
    int         idx_log[$];
    int         last_data = 0;
    bit         mon_on = 0;

    bit         prev_stall = 0;
    bit         prev_rst = 1;
    logic [7:0] prev_d;
    logic       prev_l;
    logic [3:0] prev_i;

    always @(negedge clk) begin : mon
        logic [1:0] bf;
        int nm;
        if (mon_on) begin
            bf = '0;
            foreach (map_bank[k]) bf[map_bank[k]] = 1'b1;
            chk("bank_full", bank_full, bf);
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_short", err_short, m_short);
            if (prev_stall && !prev_rst) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
                chk("stall_last", out_last, prev_l);
                chk("stall_idx", out_filter_idx, prev_i);
            end
            if (out_valid) begin
                if (map_filt.size() == 0) begin
                    chk("valid_without_map", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_pix[0]);
                    chk("out_last", out_last, beat == MAP_SIZE - 1);
                    chk("out_filter_idx", out_filter_idx, map_filt[0]);
                end
            end else begin
                chk("out_last_idle", out_last, 0);
            end

            if (reset) begin
                part.delete();
                exp_pix.delete();
                map_filt.delete();
                map_bank.delete();
                m_filt  = 0;
                m_seq   = 0;
                m_ovf   = 0;
                m_short = 0;
                beat    = 0;
            end else begin
                nm = map_filt.size();
                if (new_filter) begin
                    if (part.size() != 0) begin
                        part.delete();
                        m_short = 1;
                    end
                end else if (pool_valid) begin
                    if (nm == 2) begin
                        m_ovf = 1;
                    end else begin
                        part.push_back(pool_data);
                        if (part.size() == MAP_SIZE) begin
                            foreach (part[k]) exp_pix.push_back(part[k]);
                            part.delete();
                            map_filt.push_back(m_filt);
                            map_bank.push_back(m_seq % 2);
                            m_seq++;
                            m_filt = (m_filt + 1) % NUM_FILTERS;
                        end
                    end
                end
                if (out_valid && out_ready && nm > 0) begin
                    last_data = exp_pix[0];
                    void'(exp_pix.pop_front());
                    if (beat == MAP_SIZE - 1) begin
                        idx_log.push_back(map_filt[0]);
                        void'(map_filt.pop_front());
                        void'(map_bank.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_rst   = reset;
            prev_d     = out_data;
            prev_l     = out_last;
            prev_i     = out_filter_idx;
        end
    end

    // 0: never ready, 1: always ready, 2: random 50%
    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pool_valid = 1'b0;
        new_filter = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // mode 0: i, 1: random, 2: 255-i
    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            pool_valid = 1'b1;
            case (mode)
                0: pool_data = 8'(i);
                1: pool_data = 8'($urandom);
                default: pool_data = 8'(255 - i);
            endcase
            tick();
        end
        pool_valid = 1'b0;
    endtask

    task automatic feed_gappy(input int n);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                pool_valid = 1'b0;
                tick();
            end
            pool_valid = 1'b1;
            pool_data  = 8'($urandom);
            tick();
        end
        pool_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((map_filt.size() != 0 || out_valid) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: busy after %0d cycles, want idle", c);
        end
    endtask

    initial begin
        int c;
        reset = 1'b1;
        tick();
        tick();
        mon_on = 1;
        chk("rst_valid", out_valid, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_err_ovf", err_overflow, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_filter_idx, 0);
        reset = 1'b0;

        // 1: single map, latency and ordering
        ready_mode = 1;
        idx_log.delete();
        new_filter = 1'b1;
        tick();
        new_filter = 1'b0;
        tick();
        chk("t1_nf_empty_short", err_short, 0);
        feed(MAP_SIZE, 0);
        chk("t1_bank_full", bank_full, 2'b01);
        chk("t1_valid_lat0", out_valid, 0);
        tick();
        chk("t1_valid_lat1", out_valid, 0);
        tick();
        chk("t1_valid_lat2", out_valid, 1);
        chk("t1_first_data", out_data, 0);
        chk("t1_first_idx", out_filter_idx, 0);
        wait_drain(400);
        chk("t1_last_data", last_data, 143);
        chk("t1_maps", idx_log.size(), 1);
        chk("t1_idx", idx_log[0], 0);

        // 2: three maps, alternating banks
        do_reset();
        idx_log.delete();
        for (int m = 0; m < 3; m++) begin
            feed(MAP_SIZE, 1);
            chk("t2_bank_full", bank_full, (m % 2 == 1) ? 2'b10 : 2'b01);
            wait_drain(400);
        end
        chk("t2_err_ovf", err_overflow, 0);
        chk("t2_err_short", err_short, 0);
        chk("t2_maps", idx_log.size(), 3);
        for (int m = 0; m < 3; m++) chk("t2_idx", idx_log[m], m);

        // 3: overflow while downstream is stalled
        do_reset();
        idx_log.delete();
        ready_mode = 0;
        tick();
        feed(MAP_SIZE, 1);
        feed(MAP_SIZE, 1);
        chk("t3_both_full", bank_full, 2'b11);
        chk("t3_no_ovf_yet", err_overflow, 0);
        feed(MAP_SIZE, 1);
        chk("t3_err_ovf", err_overflow, 1);
        ready_mode = 1;
        wait_drain(800);
        chk("t3_maps", idx_log.size(), 2);
        chk("t3_idx1", idx_log[1], 1);

        // 4: random backpressure, then gappy back-to-back maps
        do_reset();
        idx_log.delete();
        ready_mode = 2;
        feed(MAP_SIZE, 0);
        wait_drain(1500);
        chk("t4_last_data", last_data, 143);
        chk("t4_maps", idx_log.size(), 1);
        feed_gappy(3 * MAP_SIZE);
        wait_drain(3000);

        // 5: restart after a partial map, colliding with a pixel
        do_reset();
        idx_log.delete();
        ready_mode = 1;
        feed(50, 1);
        new_filter = 1'b1;
        pool_valid = 1'b1;
        pool_data  = 8'hAA;
        tick();
        new_filter = 1'b0;
        pool_valid = 1'b0;
        chk("t5_err_short", err_short, 1);
        chk("t5_no_map", bank_full, 0);
        feed(MAP_SIZE, 2);
        chk("t5_bank_full", bank_full, 2'b01);
        tick();
        tick();
        chk("t5_valid", out_valid, 1);
        chk("t5_first_data", out_data, 8'hFF);
        wait_drain(400);
        chk("t5_last_data", last_data, 112);
        chk("t5_idx", idx_log[0], 0);

        // 6: reset in the middle of a replay
        do_reset();
        idx_log.delete();
        feed(MAP_SIZE, 1);
        c = 0;
        while (beat != 70 && c < 300) begin
            tick();
            c++;
        end
        chk("t6_reached_beat70", beat, 70);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", out_valid, 0);
        chk("t6_bank_full", bank_full, 0);
        chk("t6_err_ovf", err_overflow, 0);
        chk("t6_err_short", err_short, 0);
        idx_log.delete();
        feed(MAP_SIZE, 2);
        tick();
        tick();
        chk("t6_fresh_valid", out_valid, 1);
        chk("t6_fresh_data", out_data, 8'hFF);
        chk("t6_fresh_idx", out_filter_idx, 0);
        wait_drain(400);
        chk("t6_maps", idx_log.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
